// File: rtl/aes_inv_cipher_iter_if.sv
// Bundles the data and control signals of the iterative AES inverse cipher.
// The controller drives enable/in/expansion/key; the cipher drives out/done.
interface aes_inv_cipher_iter_if #(
  parameter int NK = 4,
  parameter int NR = 10
);
  logic [NK*32-1:0]       key;
  logic                   enable;
  logic [127:0]           in;
  logic [(NR+1)*128-1:0]  expansion;
  logic [127:0]           out;
  logic                   done;

  modport master (
    output key, enable, in, expansion,
    input  out, done
  );

  modport slave (
    input  key, enable, in, expansion,
    output out, done
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher: one round per enabled clock, with
// every intermediate state shown on out so a display path can step through it.
module aes_inv_cipher_iter #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_inv_cipher_iter_if.slave bus
);

  localparam int              RC_W    = $clog2(NR + 2);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(NR);
  localparam logic [RC_W-1:0] RC_IDLE = RC_W'(NR + 1);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef struct packed {
    logic [7:0] m9;
    logic [7:0] mb;
    logic [7:0] md;
    logic [7:0] me;
  } inv_mul_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Products by {09,0b,0d,0e} from one shared xtime chain.
  function automatic inv_mul_t inv_mul(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    inv_mul_t   m;
    x2   = xtime(b);
    x4   = xtime(x2);
    x8   = xtime(x4);
    m.m9 = x8 ^ b;
    m.mb = x8 ^ x2 ^ b;
    m.md = x8 ^ x4 ^ b;
    m.me = x8 ^ x4 ^ x2;
    return m;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c - row + 4) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    inv_mul_t a0, a1, a2, a3;
    a0 = inv_mul(col[31:24]);
    a1 = inv_mul(col[23:16]);
    a2 = inv_mul(col[15:8]);
    a3 = inv_mul(col[7:0]);
    return {a0.me ^ a1.mb ^ a2.md ^ a3.m9,
            a0.m9 ^ a1.me ^ a2.mb ^ a3.md,
            a0.md ^ a1.m9 ^ a2.me ^ a3.mb,
            a0.mb ^ a1.md ^ a2.m9 ^ a3.me};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
    end
    return r;
  endfunction

  logic [127:0]    state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            done_q, done_d;
  logic [RC_W-1:0] key_idx;
  logic [127:0]    round_key;
  logic [127:0]    sub_shift;

  // The key port exists only to mirror the encryptor; the schedule arrives precomputed.
  logic [NK*32-1:0] unused_key;
  assign unused_key = bus.key;

  // Round keys are consumed last-to-first: rk[NR] on the load cycle, rk[0] on the final round.
  assign key_idx   = (rc_q == '0) ? RC_LAST : RC_LAST - rc_q;
  assign sub_shift = inv_sub_bytes(inv_shift_rows(state_q));

  always_comb begin
    round_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (key_idx == RC_W'(i)) begin
        round_key = bus.expansion[(NR+1-i)*128-1 -: 128];
      end
    end
  end

  // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    done_d  = done_q;
    if (rc_q == '0) begin
      state_d = bus.in ^ round_key;
      rc_d    = RC_W'(1);
    end else if (rc_q < RC_LAST) begin
      state_d = inv_mix_columns(sub_shift ^ round_key);
      rc_d    = rc_q + RC_W'(1);
    end else if (rc_q == RC_LAST) begin
      state_d = sub_shift ^ round_key;
      rc_d    = RC_IDLE;
      done_d  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      state_q <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
    end
  end

  assign bus.out  = state_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter at all three key sizes, against a
// byte-array FIPS-197 model whose S-boxes are derived from GF(2^8) arithmetic.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] EDGE1_128 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [127:0] mrk [15];
  logic [127:0] mstate [15];

  aes_inv_cipher_iter_if #(.NK(4), .NR(10)) if128 ();
  aes_inv_cipher_iter_if #(.NK(6), .NR(12)) if192 ();
  aes_inv_cipher_iter_if #(.NK(8), .NR(14)) if256 ();

  aes_inv_cipher_iter #(.NK(4), .NR(10)) u_dut128 (.clk(clk), .reset(reset), .bus(if128.slave));
  aes_inv_cipher_iter #(.NK(6), .NR(12)) u_dut192 (.clk(clk), .reset(reset), .bus(if192.slave));
  aes_inv_cipher_iter #(.NK(8), .NR(14)) u_dut256 (.clk(clk), .reset(reset), .bus(if256.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sboxes();
    logic [7:0] inv, s, x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[v]  = s;
      isbox[s] = x;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mstate[k-1] is the state expected after the k-th enabled edge.
  task automatic model_run(input logic [127:0] ct, input int nr);
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   coef [4];
    logic [127:0] v;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    v = ct ^ mrk[nr];
    mstate[0] = v;
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int i = 0; i < 16; i++) st[i] = v[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          tmp[4*c+r] = isbox[st[4*((c - r + 4) % 4) + r]];
      v = mrk[rnd];
      for (int i = 0; i < 16; i++) tmp[i] = tmp[i] ^ v[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rnd > 0) begin
            st[4*c+r] = 8'h00;
            for (int j = 0; j < 4; j++)
              st[4*c+r] = st[4*c+r] ^ gmul(tmp[4*c+j], coef[(j - r + 4) % 4]);
          end else begin
            st[4*c+r] = tmp[4*c+r];
          end
        end
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = st[i];
      mstate[nr-rnd] = v;
    end
  endtask

  // ---------------- DUT access helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input int sz, input logic en);
    case (sz)
      128:     if128.enable = en;
      192:     if192.enable = en;
      default: if256.enable = en;
    endcase
  endtask

  task automatic set_in(input int sz, input logic [127:0] v);
    case (sz)
      128:     if128.in = v;
      192:     if192.in = v;
      default: if256.in = v;
    endcase
  endtask

  task automatic load_exp(input int sz);
    for (int i = 0; i <= 10; i++) if (sz == 128) if128.expansion[(11-i)*128-1 -: 128] = mrk[i];
    for (int i = 0; i <= 12; i++) if (sz == 192) if192.expansion[(13-i)*128-1 -: 128] = mrk[i];
    for (int i = 0; i <= 14; i++) if (sz == 256) if256.expansion[(15-i)*128-1 -: 128] = mrk[i];
  endtask

  function automatic logic [127:0] dut_out(input int sz);
    case (sz)
      128:     return if128.out;
      192:     return if192.out;
      default: return if256.out;
    endcase
  endfunction

  function automatic logic dut_done(input int sz);
    case (sz)
      128:     return if128.done;
      192:     return if192.done;
      default: return if256.done;
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want)
      else begin
        failures++;
        $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
  endtask

  task automatic check_out(input int sz, input string tag, input logic [127:0] want_out,
                           input logic want_done);
    check({tag, " out"}, dut_out(sz), want_out);
    check({tag, " done"}, {127'b0, dut_done(sz)}, {127'b0, want_done});
  endtask

  // Full run from a cleared state, every intermediate state and the idle hold checked.
  task automatic run_full(input int sz, input logic [127:0] ct, input string tag);
    int nr;
    nr = (sz == 128) ? 10 : (sz == 192) ? 12 : 14;
    model_run(ct, nr);
    set_in(sz, ct);
    set_en(sz, 1'b1);
    for (int k = 1; k <= nr + 1; k++) begin
      tick();
      check_out(sz, $sformatf("%s edge%0d", tag, k), mstate[k-1], k == nr + 1);
    end
    tick();
    check_out(sz, {tag, " hold"}, mstate[nr], 1'b1);
    set_en(sz, 1'b0);
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [255:0] rkey;
    logic [127:0] rct;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    if128.enable = 1'b0; if128.key = '0; if128.in = '0; if128.expansion = '0;
    if192.enable = 1'b0; if192.key = '0; if192.in = '0; if192.expansion = '0;
    if256.enable = 1'b0; if256.key = '0; if256.in = '0; if256.expansion = '0;
    build_sboxes();
    tick();
    tick();
    check_out(128, "reset128", 128'h0, 1'b0);
    check_out(192, "reset192", 128'h0, 1'b0);
    check_out(256, "reset256", 128'h0, 1'b0);
    reset = 1'b0;

    // AES-128 known vector, then final value against the published plaintext.
    expand_key(KEY128, 4);
    load_exp(128);
    set_in(128, CT128);
    set_en(128, 1'b1);
    tick();
    check_out(128, "v128 edge1", EDGE1_128, 1'b0);
    repeat (10) tick();
    check_out(128, "v128 final", PT, 1'b1);
    repeat (3) tick();
    check_out(128, "v128 hold", PT, 1'b1);
    set_en(128, 1'b0);
    tick();
    check_out(128, "v128 disable", 128'h0, 1'b0);
    run_full(128, CT128, "v128 steps");

    // Input changed after the sampling edge must not matter.
    set_in(128, CT128);
    set_en(128, 1'b1);
    tick();
    set_in(128, 128'h0);
    repeat (10) tick();
    check_out(128, "in ignored", PT, 1'b1);
    set_en(128, 1'b0);
    tick();

    // Reset mid-run, then restart.
    model_run(CT128, 10);
    set_in(128, CT128);
    set_en(128, 1'b1);
    repeat (5) tick();
    check_out(128, "pre-reset edge5", mstate[4], 1'b0);
    reset = 1'b1;
    tick();
    check_out(128, "mid reset", 128'h0, 1'b0);
    reset = 1'b0;
    repeat (10) tick();
    check_out(128, "restart edge10", mstate[9], 1'b0);
    tick();
    check_out(128, "restart final", PT, 1'b1);
    set_en(128, 1'b0);
    tick();

    // Enable dropped for one cycle at edge 6.
    set_en(128, 1'b1);
    repeat (5) tick();
    set_en(128, 1'b0);
    tick();
    check_out(128, "enable drop", 128'h0, 1'b0);
    set_en(128, 1'b1);
    tick();
    check_out(128, "reenable edge1", EDGE1_128, 1'b0);
    repeat (10) tick();
    check_out(128, "reenable final", PT, 1'b1);
    set_en(128, 1'b0);
    tick();

    // AES-192 and AES-256 known vectors.
    expand_key(KEY192, 6);
    load_exp(192);
    set_in(192, CT192);
    set_en(192, 1'b1);
    repeat (13) tick();
    check_out(192, "v192 final", PT, 1'b1);
    set_en(192, 1'b0);
    tick();
    run_full(192, CT192, "v192 steps");

    expand_key(KEY256, 8);
    load_exp(256);
    set_in(256, CT256);
    set_en(256, 1'b1);
    repeat (15) tick();
    check_out(256, "v256 final", PT, 1'b1);
    set_en(256, 1'b0);
    tick();
    run_full(256, CT256, "v256 steps");

    // Random keys and ciphertexts at every key size.
    for (int n = 0; n < 3; n++) begin
      for (int s = 0; s < 3; s++) begin
        for (int w = 0; w < 8; w++) rkey[255-32*w -: 32] = $urandom;
        rct = {$urandom, $urandom, $urandom, $urandom};
        expand_key(rkey, 4 + 2 * s);
        load_exp(128 + 64 * s);
        run_full(128 + 64 * s, rct, $sformatf("rand%0d sz%0d", n, 128 + 64 * s));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES inverse cipher (FIPS-197 InvCipher) for AES-128/192/256, selected by parameters.
- Performs one round per enabled clock and shows every intermediate state on `out`, so a display path can step through decryption.
- Takes a precomputed key schedule from the key-expansion block and ciphertext from the encryptor output path.
- Sits beside the iterative encryptor in the top-level demo. Its output feeds the byte-to-7-segment display chain.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8).
- NR, 10, number of rounds (10/12/14); must match NK (4→10, 6→12, 8→14).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- key, input, NK*32, cipher key. Reserved for interface symmetry with the encryptor; ignored.
- enable, input, 1, run/hold control.
- in, input, 128, ciphertext, sampled on the first enabled cycle only.
- expansion, input, (NR+1)*128, key schedule. Round key i = expansion[(NR+1-i)*128-1 -: 128], so round key 0 occupies the MSBs.
- out, output, 128, current state.
- done, output, 1, high once the plaintext is on `out`.

Behaviour:
- State byte order: bits[127:120] = s(0,0), [119:112] = s(1,0), and so on, column-major per FIPS-197.
- Internal registers:
  - round counter rc, range 0..NR+1;
  - 128-bit state register, driving `out`.
- reset=1 at a clock edge: out←0, rc←0, done←0. Reset has priority over enable.
- enable=0 (reset=0): same clearing as reset (out←0, rc←0, done←0). Deasserting enable mid-operation aborts the run; the next enabled cycle restarts from `in`.
- enable=1, rc=0: out ← in XOR rk[NR]; rc←1. Only this cycle samples `in`; later changes to `in` are ignored.
- enable=1, 1≤rc≤NR−1, with r = NR−rc:
  - out ← InvMixColumns(InvSubBytes(InvShiftRows(out)) XOR rk[r]);
  - rc←rc+1.
- enable=1, rc=NR:
  - out ← InvSubBytes(InvShiftRows(out)) XOR rk[0];
  - rc←NR+1, done←1.
- enable=1, rc=NR+1: hold out and done (idle), no wrap.
- Latency: plaintext appears on `out` after NR+1 enabled edges; each intermediate round state is visible for one cycle.
- InvShiftRows: row k rotated right by k bytes.
- InvSubBytes: FIPS-197 inverse S-box, 256-entry combinational table, 16 instances.
- InvMixColumns: GF(2^8) multiplication by {0e,0b,0d,09}, reduction polynomial 0x11B, built from xtime chains. Purely combinational; no multi-cycle ops.
- `expansion` and `in` are treated as stable; no handshake beyond `enable`.
- All three key sizes are one RTL body, parameterised.
- `done` is registered and aligned with the final `out` value.

Test Plan:
- AES-128 vector:
  - Stimulus: NK=4/NR=10, expansion from key 000102030405060708090a0b0c0d0e0f, in=69c4e0d86a7b0430d8cdb78070b4c55a, reset then enable=1.
  - After edge 1: out=7ad5fda789ef4e272bca100b3d9ff59f.
  - After edge 11: out=00112233445566778899aabbccddeeff, done=1.
  - Further edges: holds.
- AES-192 vector:
  - Stimulus: NK=6/NR=12, key 000102…1617, in=dda97ca4864cdfe06eaf70a0ec0d7191.
  - After 13 enabled edges: out=00112233445566778899aabbccddeeff, done=1.
- AES-256 vector:
  - Stimulus: NK=8/NR=14, key 000102…1e1f, in=8ea2b7ca516745bfeafc49904b496089.
  - After 15 enabled edges: out=00112233445566778899aabbccddeeff, done=1.
- Input ignored after sampling:
  - Stimulus: AES-128 run with `in` changed to 0 after edge 1.
  - Required: final out is still 00112233445566778899aabbccddeeff.
- Reset mid-run:
  - Stimulus: assert reset for 1 cycle after edge 5 of an AES-128 run.
  - Required: out=0, done=0. A restarted run again produces the plaintext after 11 further enabled edges.
- Enable drop:
  - Stimulus: enable=0 for 1 cycle at edge 6.
  - Required: out=0, rc cleared. The next enabled edge gives in XOR rk[NR] (7ad5fda7… for the AES-128 vector).
